// File: rtl/match_mem_ctrl_if.sv
// match_mem_ctrl_if: one feature-store bank port.
// Address, write data and enable out; read data back.
interface match_mem_ctrl_if #(
  parameter int FEAT_W = 292
);
  logic [10:0]       addr;
  logic [FEAT_W-1:0] wdata;
  logic              wen;
  logic [FEAT_W-1:0] rdata;

  modport master (
    output addr,
    output wdata,
    output wen,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  wen,
    output rdata
  );
endinterface

// File: rtl/match_mem_ctrl.sv
// match_mem_ctrl: dual-bank feature store sequencer.
// Ping-pongs banks per frame, all-pairs read scan at frame end.
module match_mem_ctrl #(
  parameter int MAX_PTS = 512,
  parameter int RD_LAT  = 3,
  parameter int FEAT_W  = 292
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_feat_valid,
  input  logic [FEAT_W-1:0]          i_feat_data,
  output logic                       o_feat_ready,
  input  logic                       i_frame_end,
  output logic                       o_overflow,
  match_mem_ctrl_if.master           mem1,
  match_mem_ctrl_if.master           mem2,
  output logic                       o_pair_valid,
  output logic [$clog2(MAX_PTS)-1:0] o_pair_idx1,
  output logic [$clog2(MAX_PTS)-1:0] o_pair_idx2,
  output logic [FEAT_W-1:0]          o_feat1,
  output logic [FEAT_W-1:0]          o_feat2,
  output logic                       o_pair_last,
  output logic                       o_scan_done
);
  localparam int IW = $clog2(MAX_PTS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FLIP
  } state_t;

  state_t state_q, state_d;

  logic          ready_q, done_q, ovf_q;
  logic          wr_sel, rd_sel, prev_valid;
  logic [CW-1:0] wr_cnt, old_cnt, new_cnt, fe_cnt;
  logic [IW-1:0] i_q, j_q;
  logic [3:0]    dcnt;
  logic          accept, wr_ok, fe_ok;
  logic          j_wrap, scan_last;

  logic [10:0]       a1_q, a2_q;
  logic [FEAT_W-1:0] d1_q, d2_q;
  logic              w1_q, w2_q;

  logic          iss_v, iss_l;
  logic [IW-1:0] iss_i, iss_j;
  logic          pv [RD_LAT];
  logic          pl [RD_LAT];
  logic [IW-1:0] pi [RD_LAT];
  logic [IW-1:0] pj [RD_LAT];

  assign accept = i_feat_valid & ready_q;
  assign wr_ok  = accept && (wr_cnt < CW'(MAX_PTS));
  assign fe_ok  = (state_q == IDLE) && i_frame_end;
  assign fe_cnt = wr_cnt + CW'(wr_ok);

  assign j_wrap    = CW'(j_q) == new_cnt - CW'(1);
  assign scan_last = j_wrap &&
                     (CW'(i_q) == old_cnt - CW'(1));

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_frame_end) begin
          if (!prev_valid || old_cnt == '0 ||
              fe_cnt == '0)
            state_d = FLIP;
          else
            state_d = SCAN;
        end
      end
      SCAN:  if (scan_last) state_d = DRAIN;
      DRAIN: if (dcnt == 4'(RD_LAT - 1)) state_d = FLIP;
      FLIP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, frame counters, scan indices and bank roles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      prev_valid <= 1'b0;
      wr_cnt     <= '0;
      old_cnt    <= '0;
      new_cnt    <= '0;
      i_q        <= '0;
      j_q        <= '0;
      dcnt       <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      done_q  <= (state_q == FLIP);
      if (accept) begin
        if (wr_ok) wr_cnt <= wr_cnt + CW'(1);
        else       ovf_q  <= 1'b1;
      end
      if (fe_ok) begin
        new_cnt    <= fe_cnt;
        ovf_q      <= 1'b0;
        prev_valid <= 1'b1;
        rd_sel     <= wr_sel;
        i_q        <= '0;
        j_q        <= '0;
        dcnt       <= '0;
      end
      if (state_q == SCAN) begin
        if (j_wrap) begin
          j_q <= '0;
          i_q <= i_q + IW'(1);
        end else begin
          j_q <= j_q + IW'(1);
        end
      end
      if (state_q == DRAIN) dcnt <= dcnt + 4'd1;
      if (state_q == FLIP) begin
        wr_sel  <= ~wr_sel;
        wr_cnt  <= '0;
        old_cnt <= new_cnt;
      end
    end
  end

  // Bank ports: scan reads, otherwise accepted writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      w1_q <= 1'b0;
      w2_q <= 1'b0;
    end else begin
      w1_q <= 1'b0;
      w2_q <= 1'b0;
      if (state_q == SCAN) begin
        a1_q <= 11'(wr_sel ? i_q : j_q);
        a2_q <= 11'(wr_sel ? j_q : i_q);
      end else if (wr_ok) begin
        if (wr_sel) begin
          a2_q <= 11'(wr_cnt);
          d2_q <= i_feat_data;
          w2_q <= 1'b1;
        end else begin
          a1_q <= 11'(wr_cnt);
          d1_q <= i_feat_data;
          w1_q <= 1'b1;
        end
      end
    end
  end

  // Tags that travel with the reads until rdata lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iss_v <= 1'b0;
      iss_l <= 1'b0;
      iss_i <= '0;
      iss_j <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pv[k] <= 1'b0;
        pl[k] <= 1'b0;
        pi[k] <= '0;
        pj[k] <= '0;
      end
    end else begin
      iss_v <= (state_q == SCAN);
      iss_l <= (state_q == SCAN) && scan_last;
      iss_i <= i_q;
      iss_j <= j_q;
      pv[0] <= iss_v;
      pl[0] <= iss_l;
      pi[0] <= iss_i;
      pj[0] <= iss_j;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pl[k] <= pl[k-1];
        pi[k] <= pi[k-1];
        pj[k] <= pj[k-1];
      end
    end
  end

  assign mem1.addr  = a1_q;
  assign mem1.wdata = d1_q;
  assign mem1.wen   = w1_q;
  assign mem2.addr  = a2_q;
  assign mem2.wdata = d2_q;
  assign mem2.wen   = w2_q;

  assign o_feat_ready = ready_q;
  assign o_overflow   = ovf_q;
  assign o_scan_done  = done_q;
  assign o_pair_valid = pv[RD_LAT-1];
  assign o_pair_last  = pv[RD_LAT-1] & pl[RD_LAT-1];
  assign o_pair_idx1  = pv[RD_LAT-1] ? pi[RD_LAT-1] : '0;
  assign o_pair_idx2  = pv[RD_LAT-1] ? pj[RD_LAT-1] : '0;

  assign o_feat1 = !pv[RD_LAT-1] ? '0 :
                   rd_sel ? mem1.rdata : mem2.rdata;
  assign o_feat2 = !pv[RD_LAT-1] ? '0 :
                   rd_sel ? mem2.rdata : mem1.rdata;
endmodule
